dmem_access_sequencer: RTL and testbench

- Multi-cycle sequencer between the MEM pipeline stage and a handshaked data memory.
- Converts one load or store (width and sign taken from load_src/store_src) into one or two aligned word transactions.
- Splits misaligned accesses, merges and extends read data, and drives a stall to the hazard unit until the access completes.
- Includes a watchdog on memory response time.

---
 rtl/dmem_access_sequencer_if.sv | 24 ++
 rtl/dmem_access_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_access_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_access_sequencer_if : handshaked data-memory bus            rev 1.0
// ---------------------------------------------------------------------------
interface dmem_access_sequencer_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_access_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_access_sequencer : MEM-stage load/store to word bus, split/merge/wdog  rev 1.0
// ---------------------------------------------------------------------------
module dmem_access_sequencer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        mem_valid,
  input  wire logic        is_store,
  input  wire logic [2:0]  load_src,
  input  wire logic [1:0]  store_src,
  input  wire logic        flush,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] wdata,
  output logic             stall,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             err,
  dmem_access_sequencer_if.master dm
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, DONE = 2'd3} state_t;

  localparam logic [16:0] MAX_WAIT_W = 17'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  lsrc_q, lsrc_d;
  logic [1:0]  ssrc_q, ssrc_d;
  logic [1:0]  off_q, off_d;
  logic        drop_q, drop_d;
  logic        abort_q, abort_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [15:0] wd_q, wd_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  logic [7:0]  in_lanes, lat_lanes;
  logic [16:0] wd_next;
  logic [63:0] merged;
  logic [31:0] sw;
  logic [31:0] ext;

  // Byte lanes over two consecutive words: bits 3:0 beat 1, bits 7:4 beat 2.
  function automatic logic [7:0] lanes(input logic st, input logic [2:0] ls,
                                       input logic [1:0] ss, input logic [1:0] off);
    logic [7:0] m;
    if (st) begin
      case (ss)
        2'b01:   m = 8'b0000_0011;
        2'b10:   m = 8'b0000_0001;
        default: m = 8'b0000_1111;
      endcase
    end else begin
      case (ls)
        3'b001, 3'b011: m = 8'b0000_0011;
        3'b010, 3'b100: m = 8'b0000_0001;
        default:        m = 8'b0000_1111;
      endcase
    end
    return m << off;
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] w, input logic [1:0] off);
    logic [63:0] t;
    t = {w, w} << {off, 3'b000};
    return t[63:32];
  endfunction

  always_comb begin
    in_lanes  = lanes(is_store, load_src, store_src, addr[1:0]);
    lat_lanes = lanes(store_q, lsrc_q, ssrc_q, off_q);
    wd_next   = {1'b0, wd_q} + 17'd1;
    merged    = {hi_q, lo_q} >> {off_q, 3'b000};
    sw        = merged[31:0];
    case (lsrc_q)
      3'b001:  ext = {{16{sw[15]}}, sw[15:0]};
      3'b010:  ext = {{24{sw[7]}}, sw[7:0]};
      3'b011:  ext = {16'h0000, sw[15:0]};
      3'b100:  ext = {24'h000000, sw[7:0]};
      default: ext = sw;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    lsrc_d     = lsrc_q;
    ssrc_d     = ssrc_q;
    off_d      = off_q;
    drop_d     = drop_q;
    abort_d    = abort_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    wd_d       = wd_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    stall      = 1'b0;
    rvalid     = 1'b0;
    err        = 1'b0;
    rdata      = 32'h0;

    case (state_q)
      IDLE: begin
        stall = mem_valid && !flush;
        if (mem_valid && !flush) begin
          store_d    = is_store;
          lsrc_d     = load_src;
          ssrc_d     = store_src;
          off_d      = addr[1:0];
          drop_d     = 1'b0;
          abort_d    = 1'b0;
          hi_d       = 32'h0;
          wd_d       = 16'h0;
          dm_req_d   = 1'b1;
          dm_we_d    = is_store;
          dm_addr_d  = {addr[31:2], 2'b00};
          dm_be_d    = in_lanes[3:0];
          dm_wdata_d = rotl8(wdata, addr[1:0]);
          state_d    = ACC1;
        end
      end
      ACC1, ACC2: begin
        stall = 1'b1;
        if (flush) drop_d = 1'b1;
        if (dm.dm_ready) begin
          if (state_q == ACC1) lo_d = dm.dm_rdata;
          else                 hi_d = dm.dm_rdata;
          wd_d = 16'h0;
          // A flush arriving with beat 1 still cancels the pending second beat.
          if (state_q == ACC1 && lat_lanes[7:4] != 4'b0000 && !drop_q && !flush) begin
            dm_addr_d = {dm_addr_q[31:2] + 30'd1, 2'b00};
            dm_be_d   = lat_lanes[7:4];
            state_d   = ACC2;
          end else begin
            dm_req_d = 1'b0;
            state_d  = DONE;
          end
        end else if (wd_next == MAX_WAIT_W) begin
          dm_req_d = 1'b0;
          abort_d  = 1'b1;
          state_d  = DONE;
        end else begin
          wd_d = wd_next[15:0];
        end
      end
      DONE: begin
        rvalid  = !store_q && !drop_q;
        err     = abort_q;
        rdata   = (rvalid && !abort_q) ? ext : 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      lsrc_q     <= 3'b000;
      ssrc_q     <= 2'b00;
      off_q      <= 2'b00;
      drop_q     <= 1'b0;
      abort_q    <= 1'b0;
      lo_q       <= 32'h0;
      hi_q       <= 32'h0;
      wd_q       <= 16'h0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_be_q    <= 4'h0;
      dm_wdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      lsrc_q     <= lsrc_d;
      ssrc_q     <= ssrc_d;
      off_q      <= off_d;
      drop_q     <= drop_d;
      abort_q    <= abort_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      wd_q       <= wd_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_be    = dm_be_q;
  assign dm.dm_wdata = dm_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_access_sequencer : directed self-checking bench           rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  load_src = 3'b000;
  logic [1:0]  store_src = 2'b00;
  logic        flush = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_access_sequencer_if bus ();

  dmem_access_sequencer #(.MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .is_store  (is_store),
    .load_src  (load_src),
    .store_src (store_src),
    .flush     (flush),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err),
    .dm        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a request in IDLE, checks the combinational stall, advances into ACC1.
  task automatic issue(input logic st, input logic [2:0] ls, input logic [1:0] ss,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1'b1; is_store = st; load_src = ls; store_src = ss; addr = a; wdata = wd;
    #1;
    chk("idle_stall", {31'b0, stall}, 32'h1);
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic [31:0] rd);
    chk({tag, "_req"},  {31'b0, bus.dm_req}, 32'h1);
    chk({tag, "_addr"}, bus.dm_addr, ea);
    chk({tag, "_be"},   {28'b0, bus.dm_be}, {28'b0, ebe});
    chk({tag, "_stall"}, {31'b0, stall}, 32'h1);
    bus.dm_ready = 1'b1; bus.dm_rdata = rd;
    tick();
    bus.dm_ready = 1'b0; bus.dm_rdata = 32'h0;
  endtask

  task automatic done_chk(input string tag, input logic ev, input logic [31:0] ed,
                          input logic ee);
    chk({tag, "_rvalid"}, {31'b0, rvalid}, {31'b0, ev});
    chk({tag, "_rdata"},  rdata, ed);
    chk({tag, "_err"},    {31'b0, err}, {31'b0, ee});
    chk({tag, "_stall"},  {31'b0, stall}, 32'h0);
    chk({tag, "_reqoff"}, {31'b0, bus.dm_req}, 32'h0);
    tick();
  endtask

  initial begin
    bus.dm_ready = 1'b0;
    bus.dm_rdata = 32'h0;
    #3;
    chk("rst_req",   {31'b0, bus.dm_req}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // LW aligned, single beat
    issue(1'b0, 3'b000, 2'b00, 32'h0000_0100, 32'h0);
    chk("lw_we", {31'b0, bus.dm_we}, 32'h0);
    beat("lw", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    done_chk("lw", 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("lw_idle_rvalid", {31'b0, rvalid}, 32'h0);

    // LB / LBU at byte 3
    issue(1'b0, 3'b010, 2'b00, 32'h0000_0103, 32'h0);
    beat("lb", 32'h0000_0100, 4'b1000, 32'h8011_2233);
    done_chk("lb", 1'b1, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b100, 2'b00, 32'h0000_0103, 32'h0);
    beat("lbu", 32'h0000_0100, 4'b1000, 32'h8011_2233);
    done_chk("lbu", 1'b1, 32'h0000_0080, 1'b0);

    // LW misaligned, split over two words
    issue(1'b0, 3'b000, 2'b00, 32'h0000_00FE, 32'h0);
    beat("lws1", 32'h0000_00FC, 4'b1100, 32'hAABB_0000);
    beat("lws2", 32'h0000_0100, 4'b0011, 32'h0000_CCDD);
    done_chk("lws", 1'b1, 32'hCCDD_AABB, 1'b0);

    // SH misaligned store
    issue(1'b1, 3'b000, 2'b01, 32'h0000_0203, 32'h0000_1234);
    chk("sh1_we", {31'b0, bus.dm_we}, 32'h1);
    chk("sh1_wd", {24'b0, bus.dm_wdata[31:24]}, 32'h34);
    beat("sh1", 32'h0000_0200, 4'b1000, 32'h0);
    chk("sh2_wd", {24'b0, bus.dm_wdata[7:0]}, 32'h12);
    beat("sh2", 32'h0000_0204, 4'b0001, 32'h0);
    done_chk("sh", 1'b0, 32'h0, 1'b0);

    // LH across the top of the address space wraps to word 0
    issue(1'b0, 3'b001, 2'b00, 32'hFFFF_FFFF, 32'h0);
    beat("lhw1", 32'hFFFF_FFFC, 4'b1000, 32'hAB00_0000);
    beat("lhw2", 32'h0000_0000, 4'b0001, 32'h0000_00CD);
    done_chk("lhw", 1'b1, 32'hFFFF_CDAB, 1'b0);

    // Watchdog abort with MAX_WAIT=4
    issue(1'b0, 3'b000, 2'b00, 32'h0000_0300, 32'h0);
    bus.dm_rdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      chk("wd_req_held", {31'b0, bus.dm_req}, 32'h1);
      tick();
    end
    done_chk("wd", 1'b1, 32'h0, 1'b1);
    bus.dm_rdata = 32'h0;

    // Flush during beat 1 of a split load skips beat 2 and suppresses rvalid
    issue(1'b0, 3'b000, 2'b00, 32'h0000_00FE, 32'h0);
    flush = 1'b1;
    beat("fl1", 32'h0000_00FC, 4'b1100, 32'h1111_1111);
    flush = 1'b0;
    done_chk("fl", 1'b0, 32'h0, 1'b0);

    // Flush in IDLE blocks acceptance
    mem_valid = 1'b1; flush = 1'b1; addr = 32'h0000_0100; is_store = 1'b0;
    #1;
    chk("flidle_stall", {31'b0, stall}, 32'h0);
    tick();
    mem_valid = 1'b0; flush = 1'b0;
    chk("flidle_req", {31'b0, bus.dm_req}, 32'h0);

    // Asynchronous reset in the middle of beat 2
    issue(1'b0, 3'b000, 2'b00, 32'h0000_00FE, 32'h0);
    beat("rs1", 32'h0000_00FC, 4'b1100, 32'hAABB_0000);
    chk("rs2_req_pre", {31'b0, bus.dm_req}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rs_req",   {31'b0, bus.dm_req}, 32'h0);
    chk("rs_stall", {31'b0, stall}, 32'h0);
    chk("rs_rvalid", {31'b0, rvalid}, 32'h0);
    #1;
    rst = 1'b1;
    tick();
    chk("rs_idle_req", {31'b0, bus.dm_req}, 32'h0);
    issue(1'b0, 3'b000, 2'b00, 32'h0000_0100, 32'h0);
    beat("rsl", 32'h0000_0100, 4'b1111, 32'h0BAD_F00D);
    done_chk("rsl", 1'b1, 32'h0BAD_F00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
